game_ctrl: RTL and testbench
============================

Name: game_ctrl

Overview:
- Downstream consumer of the board-selection stage and owner of the game state machine.
- Loads the chosen 12-bit board (four 3-bit tiles), lets the player move a cursor and swap adjacent tiles, and counts moves.
- Detects the solved arrangement and tracks the best (fewest-move) score.
- Drives game_status back to the board-selection stage, which only accepts a new board while status is CHOSE_BOARD.

Parameters:
- MOVE_W, 8, width of the move counter and best-score register.
- SOLVED, 12'b000_001_010_011, target tile arrangement (0123).

Ports:
- clk_d  in  1  system clock
- rst  in  1  asynchronous active-high reset
- board_in  in  12  board from the selection stage; position 0 = bits[11:9], position 3 = bits[2:0]
- start  in  1  one-cycle pulse: board confirmed, begin game
- btn_left  in  1  one-cycle pulse: cursor left
- btn_right  in  1  one-cycle pulse: cursor right
- btn_swap  in  1  one-cycle pulse: swap tiles at cursor and cursor+1
- btn_restart  in  1  one-cycle pulse: abandon or finish, return to selection
- game_status  out  2  00 CHOSE_BOARD, 01 GAMING, 10 GAME_INITIAL, 11 WINNED
- cur_board  out  12  live board in the same format as board_in
- cursor  out  2  left position of the swap pair, range 0..2
- move_cnt  out  MOVE_W  swaps in the current game
- best_cnt  out  MOVE_W  fewest moves of any won game since reset
- win_pulse  out  1  one-cycle pulse on entry to WINNED

Behaviour:
- Reset (async, active-high), all outputs registered:
  - game_status=CHOSE_BOARD, cur_board=SOLVED, cursor=0, move_cnt=0.
  - best_cnt=all-ones, meaning "no score yet".
  - win_pulse=0.
- CHOSE_BOARD:
  - Buttons other than start are ignored.
  - start -> GAME_INITIAL on the next edge.
- GAME_INITIAL (exactly one cycle):
  - cur_board<=board_in, cursor<=0, move_cnt<=0.
  - Next state GAMING.
  - board_in is sampled here, one cycle after start, so the selection stage's registered output has settled.
- GAMING, priority per cycle:
  1. Win check. If cur_board==SOLVED, next state WINNED; buttons that cycle are ignored.
     - A board loaded already solved therefore wins after one GAMING cycle with move_cnt=0.
  2. btn_restart: next state CHOSE_BOARD; cur_board, move_cnt and cursor are held.
  3. btn_swap: exchange tiles at positions cursor and cursor+1.
     - move_cnt increments and saturates at 2^MOVE_W-1.
     - The new board is win-checked on the following cycle.
  4. btn_left: cursor decrements, saturating at 0.
  5. btn_right: cursor increments, saturating at 2.
  - Lower-priority simultaneous buttons are dropped, not queued.
- Entry to WINNED:
  - win_pulse=1 for exactly that cycle.
  - best_cnt<=move_cnt if move_cnt<best_cnt; equal keeps the value.
- WINNED:
  - cur_board and move_cnt are frozen.
  - btn_restart -> CHOSE_BOARD; all other buttons are ignored.
- start outside CHOSE_BOARD is ignored.
- Reset mid-game returns to reset values immediately, including best_cnt.
- The unused 3-bit tile codes 100..111 are not checked; tiles are moved opaquely.

Decomposition:
- Shared package game_pkg:
  - Status localparams CHOSE_BOARD/GAMING/GAME_INITIAL/WINNED.
  - TILE_W=3, BOARD_W=12, SOLVED constant.
  - Also consumed by the board-selection stage and the display driver.
- One combinational sub-module, tile_swap:
  - Inputs: board[11:0], pos[1:0].
  - Output: board with tiles pos and pos+1 exchanged.
  - Reused later by any hint or auto-solve logic.

Test Plan:
- Reset, then start with board_in=000_001_011_010 (0132) -> status 00->10->01 on consecutive edges, cur_board=0132, cursor=0, move_cnt=0.
- From that game: right, right, swap -> cursor=2, cur_board=000_001_010_011, move_cnt=1; next cycle status=11, win_pulse high one cycle, best_cnt=1.
- Load 3210 (011_010_001_000) and perform a bubble-sort swap sequence of 6 swaps -> WINNED, move_cnt=6, best_cnt stays 1; restart -> status 00.
- Press left at cursor 0 and right at cursor 2 -> cursor holds; swap+left in the same cycle -> swap only, cursor unchanged.
- Load already-solved 0123 -> GAMING for one cycle, then WINNED with move_cnt=0, best_cnt=0.
- Assert rst during GAMING after 3 swaps -> outputs immediately return to reset values, best_cnt=all-ones, status=00.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the tile game: status codes, board geometry and the target arrangement.
// Also consumed by the board-selection stage and the display driver.
package game_pkg;

   localparam int TILE_W  = 3;
   localparam int BOARD_W = 12;

   localparam logic [BOARD_W-1:0] SOLVED = 12'b000_001_010_011;

   typedef enum logic [1:0] {
      CHOSE_BOARD  = 2'b00,
      GAMING       = 2'b01,
      GAME_INITIAL = 2'b10,
      WINNED       = 2'b11
   } status_e;

endpackage

// File: rtl/tile_swap.sv
// Combinational exchange of the two adjacent tiles at pos and pos+1.
// Position 0 is the most significant tile.
module tile_swap
   import game_pkg::*;
(
   input  logic [BOARD_W-1:0] board,
   input  logic [1:0]         pos,
   output logic [BOARD_W-1:0] swapped
);

   // pos 3 has no right neighbour, so the board passes through unchanged
   always_comb begin
      swapped = board;
      case (pos)
         2'd0:    swapped = {board[8:6], board[11:9], board[5:0]};
         2'd1:    swapped = {board[11:9], board[5:3], board[8:6], board[2:0]};
         2'd2:    swapped = {board[11:6], board[2:0], board[5:3]};
         default: swapped = board;
      endcase
   end

endmodule

// File: rtl/game_ctrl.sv
// Game state machine: loads a board, moves the cursor, swaps tiles, counts moves,
// detects the solved arrangement and keeps the best score since reset.
module game_ctrl #(
   parameter int                           MOVE_W = 8,
   parameter logic [game_pkg::BOARD_W-1:0] SOLVED = game_pkg::SOLVED
) (
   input  logic                          clk_d,
   input  logic                          rst,
   input  logic [game_pkg::BOARD_W-1:0]  board_in,
   input  logic                          start,
   input  logic                          btn_left,
   input  logic                          btn_right,
   input  logic                          btn_swap,
   input  logic                          btn_restart,
   output logic [1:0]                    game_status,
   output logic [game_pkg::BOARD_W-1:0]  cur_board,
   output logic [1:0]                    cursor,
   output logic [MOVE_W-1:0]             move_cnt,
   output logic [MOVE_W-1:0]             best_cnt,
   output logic                          win_pulse
);
   import game_pkg::*;

   localparam logic [MOVE_W-1:0] MOVE_MAX = {MOVE_W{1'b1}};

   status_e             state_r, state_nx_s;
   logic [BOARD_W-1:0]  board_r, board_nx_s, swapped_s;
   logic [1:0]          cursor_r, cursor_nx_s;
   logic [MOVE_W-1:0]   move_r, move_nx_s;
   logic [MOVE_W-1:0]   best_r, best_nx_s;
   logic                win_r, win_nx_s;

   tile_swap u_tile_swap (
      .board   (board_r),
      .pos     (cursor_r),
      .swapped (swapped_s)
   );

   // State and datapath registers
   always_ff @(posedge clk_d or posedge rst) begin
      if (rst) begin
         state_r  <= CHOSE_BOARD;
         board_r  <= SOLVED;
         cursor_r <= 2'd0;
         move_r   <= '0;
         best_r   <= MOVE_MAX;
         win_r    <= 1'b0;
      end else begin
         state_r  <= state_nx_s;
         board_r  <= board_nx_s;
         cursor_r <= cursor_nx_s;
         move_r   <= move_nx_s;
         best_r   <= best_nx_s;
         win_r    <= win_nx_s;
      end
   end

   // Next-state and datapath update; in GAMING the win check outranks every button
   always_comb begin
      state_nx_s  = state_r;
      board_nx_s  = board_r;
      cursor_nx_s = cursor_r;
      move_nx_s   = move_r;
      best_nx_s   = best_r;
      win_nx_s    = 1'b0;
      case (state_r)
         CHOSE_BOARD: begin
            if (start) begin
               state_nx_s = GAME_INITIAL;
            end else begin
               state_nx_s = CHOSE_BOARD;
            end
         end
         GAME_INITIAL: begin
            board_nx_s  = board_in;
            cursor_nx_s = 2'd0;
            move_nx_s   = '0;
            state_nx_s  = GAMING;
         end
         GAMING: begin
            if (board_r == SOLVED) begin
               state_nx_s = WINNED;
               win_nx_s   = 1'b1;
               if (move_r < best_r) begin
                  best_nx_s = move_r;
               end else begin
                  best_nx_s = best_r;
               end
            end else if (btn_restart) begin
               state_nx_s = CHOSE_BOARD;
            end else if (btn_swap) begin
               board_nx_s = swapped_s;
               if (move_r != MOVE_MAX) begin
                  move_nx_s = move_r + MOVE_W'(1);
               end else begin
                  move_nx_s = move_r;
               end
            end else if (btn_left) begin
               if (cursor_r != 2'd0) begin
                  cursor_nx_s = cursor_r - 2'd1;
               end else begin
                  cursor_nx_s = cursor_r;
               end
            end else if (btn_right) begin
               if (cursor_r != 2'd2) begin
                  cursor_nx_s = cursor_r + 2'd1;
               end else begin
                  cursor_nx_s = cursor_r;
               end
            end else begin
               state_nx_s = GAMING;
            end
         end
         WINNED: begin
            if (btn_restart) begin
               state_nx_s = CHOSE_BOARD;
            end else begin
               state_nx_s = WINNED;
            end
         end
         default: begin
            state_nx_s = CHOSE_BOARD;
         end
      endcase
   end

   assign game_status = state_r;
   assign cur_board   = board_r;
   assign cursor      = cursor_r;
   assign move_cnt    = move_r;
   assign best_cnt    = best_r;
   assign win_pulse   = win_r;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed vector table, reset-mid-game sequence, and random
// stimulus compared against a tile-array reference model.
module tb_game_ctrl;

   logic        clk_d = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] board_in = 12'h000;
   logic        start = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_swap = 1'b0, btn_restart = 1'b0;
   logic [1:0]  game_status;
   logic [11:0] cur_board;
   logic [1:0]  cursor;
   logic [7:0]  move_cnt, best_cnt;
   logic        win_pulse;

   int vectors = 0;
   int miscompares = 0;

   game_ctrl #(.MOVE_W(8)) dut (
      .clk_d(clk_d), .rst(rst), .board_in(board_in), .start(start),
      .btn_left(btn_left), .btn_right(btn_right), .btn_swap(btn_swap),
      .btn_restart(btn_restart), .game_status(game_status), .cur_board(cur_board),
      .cursor(cursor), .move_cnt(move_cnt), .best_cnt(best_cnt), .win_pulse(win_pulse)
   );

   always #5 clk_d = ~clk_d;

   typedef struct {
      logic        st, l, r, sw, rs;
      logic [11:0] bin;
      logic [1:0]  e_st;
      logic [11:0] e_bd;
      logic [1:0]  e_cur;
      logic [7:0]  e_mv, e_best;
      logic        e_win;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic st, logic l, logic r, logic sw, logic rs, logic [11:0] bin,
                               logic [1:0] es, logic [11:0] eb, logic [1:0] ec,
                               logic [7:0] em, logic [7:0] ebst, logic ew);
      vec_t v;
      v.st = st; v.l = l; v.r = r; v.sw = sw; v.rs = rs; v.bin = bin;
      v.e_st = es; v.e_bd = eb; v.e_cur = ec; v.e_mv = em; v.e_best = ebst; v.e_win = ew;
      return v;
   endfunction

   task automatic check(string nm, logic [1:0] es, logic [11:0] eb, logic [1:0] ec,
                        logic [7:0] em, logic [7:0] ebst, logic ew);
      vectors++;
      if (game_status !== es) begin
         miscompares++; $display("FAIL %s status: got %b want %b", nm, game_status, es);
      end
      if (cur_board !== eb) begin
         miscompares++; $display("FAIL %s board: got %h want %h", nm, cur_board, eb);
      end
      if (cursor !== ec) begin
         miscompares++; $display("FAIL %s cursor: got %0d want %0d", nm, cursor, ec);
      end
      if (move_cnt !== em) begin
         miscompares++; $display("FAIL %s move_cnt: got %0d want %0d", nm, move_cnt, em);
      end
      if (best_cnt !== ebst) begin
         miscompares++; $display("FAIL %s best_cnt: got %0d want %0d", nm, best_cnt, ebst);
      end
      if (win_pulse !== ew) begin
         miscompares++; $display("FAIL %s win_pulse: got %b want %b", nm, win_pulse, ew);
      end
   endtask

   task automatic drive(logic st, logic l, logic r, logic sw, logic rs, logic [11:0] bin);
      start = st; btn_left = l; btn_right = r; btn_swap = sw; btn_restart = rs; board_in = bin;
      @(posedge clk_d);
      #1;
   endtask

   // Reference model: mode 0 choose, 1 gaming, 2 loading, 3 won
   int m_mode, m_cur, m_mv, m_best, m_win;
   int m_t[4];

   function automatic logic [11:0] m_pack();
      logic [11:0] b;
      for (int i = 0; i < 4; i++) b[11-3*i -: 3] = m_t[i][2:0];
      return b;
   endfunction

   task automatic m_reset();
      m_mode = 0; m_cur = 0; m_mv = 0; m_best = 255; m_win = 0;
      for (int i = 0; i < 4; i++) m_t[i] = i;
   endtask

   task automatic m_step(logic st, logic l, logic r, logic sw, logic rs, logic [11:0] bin);
      int tmp;
      m_win = 0;
      if (m_mode == 0) begin
         if (st) m_mode = 2;
      end else if (m_mode == 2) begin
         for (int i = 0; i < 4; i++) m_t[i] = int'(bin[11-3*i -: 3]);
         m_cur = 0; m_mv = 0; m_mode = 1;
      end else if (m_mode == 1) begin
         if (m_t[0] == 0 && m_t[1] == 1 && m_t[2] == 2 && m_t[3] == 3) begin
            m_mode = 3; m_win = 1;
            if (m_mv < m_best) m_best = m_mv;
         end else if (rs) m_mode = 0;
         else if (sw) begin
            tmp = m_t[m_cur]; m_t[m_cur] = m_t[m_cur+1]; m_t[m_cur+1] = tmp;
            m_mv = (m_mv + 1 > 255) ? 255 : m_mv + 1;
         end else if (l) m_cur = (m_cur > 0) ? m_cur - 1 : 0;
         else if (r) m_cur = (m_cur < 2) ? m_cur + 1 : 2;
      end else begin
         if (rs) m_mode = 0;
      end
   endtask

   initial begin
      logic [11:0] rb;
      int p[4];
      int a, b, tmp;
      logic st, l, r, sw, rs;

      // Directed table: inputs for one edge, then expected outputs after it
      vecs.push_back(mk(1,0,0,0,0,12'h05A, 2'b10,12'h053,2'd0,8'd0,8'hFF,1'b0));
      vecs.push_back(mk(0,0,0,0,0,12'h05A, 2'b01,12'h05A,2'd0,8'd0,8'hFF,1'b0));
      vecs.push_back(mk(0,0,1,0,0,12'h05A, 2'b01,12'h05A,2'd1,8'd0,8'hFF,1'b0));
      vecs.push_back(mk(0,0,1,0,0,12'h05A, 2'b01,12'h05A,2'd2,8'd0,8'hFF,1'b0));
      vecs.push_back(mk(0,0,0,1,0,12'h05A, 2'b01,12'h053,2'd2,8'd1,8'hFF,1'b0));
      vecs.push_back(mk(0,0,0,0,0,12'h05A, 2'b11,12'h053,2'd2,8'd1,8'd1,1'b1));
      vecs.push_back(mk(0,0,0,0,0,12'h05A, 2'b11,12'h053,2'd2,8'd1,8'd1,1'b0));
      vecs.push_back(mk(0,0,0,1,0,12'h05A, 2'b11,12'h053,2'd2,8'd1,8'd1,1'b0));
      vecs.push_back(mk(0,0,0,0,1,12'h05A, 2'b00,12'h053,2'd2,8'd1,8'd1,1'b0));
      vecs.push_back(mk(0,1,0,0,0,12'h688, 2'b00,12'h053,2'd2,8'd1,8'd1,1'b0));
      vecs.push_back(mk(1,0,0,0,0,12'h688, 2'b10,12'h053,2'd2,8'd1,8'd1,1'b0));
      vecs.push_back(mk(0,0,0,0,0,12'h688, 2'b01,12'h688,2'd0,8'd0,8'd1,1'b0));
      vecs.push_back(mk(0,0,0,1,0,12'h688, 2'b01,12'h4C8,2'd0,8'd1,8'd1,1'b0));
      vecs.push_back(mk(0,0,1,0,0,12'h688, 2'b01,12'h4C8,2'd1,8'd1,8'd1,1'b0));
      vecs.push_back(mk(0,0,0,1,0,12'h688, 2'b01,12'h458,2'd1,8'd2,8'd1,1'b0));
      vecs.push_back(mk(0,0,1,0,0,12'h688, 2'b01,12'h458,2'd2,8'd2,8'd1,1'b0));
      vecs.push_back(mk(0,0,0,1,0,12'h688, 2'b01,12'h443,2'd2,8'd3,8'd1,1'b0));
      vecs.push_back(mk(0,1,0,0,0,12'h688, 2'b01,12'h443,2'd1,8'd3,8'd1,1'b0));
      vecs.push_back(mk(0,0,0,1,0,12'h688, 2'b01,12'h40B,2'd1,8'd4,8'd1,1'b0));
      vecs.push_back(mk(0,1,0,0,0,12'h688, 2'b01,12'h40B,2'd0,8'd4,8'd1,1'b0));
      vecs.push_back(mk(0,0,0,1,0,12'h688, 2'b01,12'h08B,2'd0,8'd5,8'd1,1'b0));
      vecs.push_back(mk(0,0,1,0,0,12'h688, 2'b01,12'h08B,2'd1,8'd5,8'd1,1'b0));
      vecs.push_back(mk(0,0,0,1,0,12'h688, 2'b01,12'h053,2'd1,8'd6,8'd1,1'b0));
      vecs.push_back(mk(0,0,0,0,0,12'h688, 2'b11,12'h053,2'd1,8'd6,8'd1,1'b1));
      vecs.push_back(mk(0,0,0,0,1,12'h688, 2'b00,12'h053,2'd1,8'd6,8'd1,1'b0));
      vecs.push_back(mk(1,0,0,0,0,12'h08B, 2'b10,12'h053,2'd1,8'd6,8'd1,1'b0));
      vecs.push_back(mk(0,0,0,0,0,12'h08B, 2'b01,12'h08B,2'd0,8'd0,8'd1,1'b0));
      vecs.push_back(mk(0,1,0,0,0,12'h08B, 2'b01,12'h08B,2'd0,8'd0,8'd1,1'b0));
      vecs.push_back(mk(0,0,1,0,0,12'h08B, 2'b01,12'h08B,2'd1,8'd0,8'd1,1'b0));
      vecs.push_back(mk(0,0,1,0,0,12'h08B, 2'b01,12'h08B,2'd2,8'd0,8'd1,1'b0));
      vecs.push_back(mk(0,0,1,0,0,12'h08B, 2'b01,12'h08B,2'd2,8'd0,8'd1,1'b0));
      vecs.push_back(mk(0,1,0,0,0,12'h08B, 2'b01,12'h08B,2'd1,8'd0,8'd1,1'b0));
      vecs.push_back(mk(0,1,0,1,0,12'h08B, 2'b01,12'h053,2'd1,8'd1,8'd1,1'b0));
      vecs.push_back(mk(0,0,0,0,0,12'h08B, 2'b11,12'h053,2'd1,8'd1,8'd1,1'b1));
      vecs.push_back(mk(0,0,0,0,1,12'h08B, 2'b00,12'h053,2'd1,8'd1,8'd1,1'b0));
      vecs.push_back(mk(1,0,0,0,0,12'h05A, 2'b10,12'h053,2'd1,8'd1,8'd1,1'b0));
      vecs.push_back(mk(0,0,0,0,0,12'h05A, 2'b01,12'h05A,2'd0,8'd0,8'd1,1'b0));
      vecs.push_back(mk(0,0,0,1,1,12'h05A, 2'b00,12'h05A,2'd0,8'd0,8'd1,1'b0));
      vecs.push_back(mk(1,0,0,0,0,12'h053, 2'b10,12'h05A,2'd0,8'd0,8'd1,1'b0));
      vecs.push_back(mk(0,0,0,0,0,12'h053, 2'b01,12'h053,2'd0,8'd0,8'd1,1'b0));
      vecs.push_back(mk(0,0,1,0,0,12'h053, 2'b11,12'h053,2'd0,8'd0,8'd0,1'b1));
      vecs.push_back(mk(0,0,0,0,1,12'h053, 2'b00,12'h053,2'd0,8'd0,8'd0,1'b0));

      repeat (2) @(posedge clk_d);
      #1;
      check("reset", 2'b00, 12'h053, 2'd0, 8'd0, 8'hFF, 1'b0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].st, vecs[i].l, vecs[i].r, vecs[i].sw, vecs[i].rs, vecs[i].bin);
         check($sformatf("vec%0d", i), vecs[i].e_st, vecs[i].e_bd, vecs[i].e_cur,
               vecs[i].e_mv, vecs[i].e_best, vecs[i].e_win);
      end

      // Reset asserted mid-game after three swaps clears everything without a clock edge
      drive(1,0,0,0,0,12'h688);
      drive(0,0,0,0,0,12'h688);
      repeat (3) drive(0,0,0,1,0,12'h688);
      check("pre_rst", 2'b01, 12'h4C8, 2'd0, 8'd3, 8'd0, 1'b0);
      #2 rst = 1'b1;
      #1 check("async_rst", 2'b00, 12'h053, 2'd0, 8'd0, 8'hFF, 1'b0);
      drive(0,0,0,0,0,12'h000);
      rst = 1'b0;
      m_reset();

      // Random stimulus against the reference model
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(9) < 7) begin
            for (int i = 0; i < 4; i++) p[i] = i;
            repeat ($urandom_range(3)) begin
               a = $urandom_range(3); b = $urandom_range(3);
               tmp = p[a]; p[a] = p[b]; p[b] = tmp;
            end
            for (int i = 0; i < 4; i++) rb[11-3*i -: 3] = p[i][2:0];
         end else begin
            rb = 12'($urandom);
         end
         st = ($urandom_range(7) == 0);
         l  = ($urandom_range(3) == 0);
         r  = ($urandom_range(3) == 0);
         sw = ($urandom_range(2) == 0);
         rs = ($urandom_range(15) == 0);
         drive(st, l, r, sw, rs, rb);
         m_step(st, l, r, sw, rs, rb);
         check($sformatf("rnd%0d", n), 2'(m_mode), m_pack(), 2'(m_cur),
               8'(m_mv), 8'(m_best), 1'(m_win));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
